lsu_subword_master: RTL
=======================

Name: lsu_subword_master

Overview:
- Load/store initiator between the MEM pipeline stage and the word-addressed data memory.
- The data memory only does whole-word access: combinational read, write on the clock edge.
- Takes byte, halfword and word load/store requests from the pipeline and drives word-granular memory cycles.
- Sub-word stores become a read-modify-write sequence; sub-word loads are extracted and sign/zero extended. Misaligned and out-of-range accesses are reported back to the pipeline.

Parameters:
- MEM_WORDS, 3072, number of 32-bit words in the data memory; word index (addr>>2) >= MEM_WORDS is out of range.
- ADDR_W, 32, width of the request and memory address buses.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous active-low reset: the block is in reset when reset==0, sampled on posedge clk.
- req_valid  input  1  pipeline request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_sign  input  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned for sub-word sizes.
- req_pc  input  32  PC of the instruction, used for trace only.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, valid with resp_valid.
- resp_err  output  1  misaligned, out-of-range or illegal size; valid with resp_valid.
- mem_addr  output  ADDR_W  word-aligned byte address to data memory.
- mem_wd  output  32  write word to data memory.
- mem_we  output  1  data memory write enable.
- mem_rd  input  32  combinational read word from data memory at mem_addr.

Behaviour:
- States: IDLE, READ, WRITE, RESP. State, captured request registers and the read buffer are all registered.
- req_ready = (state==IDLE) && reset. A request is accepted on the posedge where req_valid && req_ready; all req_* inputs are captured at that edge.
- Error check at accept:
  - size==11, half with addr[0]==1, or word with addr[1:0]!=0 -> misaligned/illegal.
  - (addr>>2) >= MEM_WORDS -> out of range.
  - Any error -> next state RESP with err flag set; no memory cycle is issued.
- Next state on a legal accept:
  - Load -> READ.
  - Word store -> WRITE.
  - Byte/half store -> READ.
- READ: drive mem_addr = {addr[ADDR_W-1:2],2'b00}; latch mem_rd into rbuf at the end of the cycle. Next state is WRITE for a store, RESP for a load.
- WRITE: drive mem_addr as in READ; mem_we=1; drive mem_wd:
  - Word: wdata.
  - Half at k=addr[1]: rbuf with bits[16k+15:16k] replaced by wdata[15:0].
  - Byte at k=addr[1:0]: rbuf with bits[8k+7:8k] replaced by wdata[7:0].
  - Lanes are little-endian. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata for loads: selected lane of rbuf, extended per req_sign.
  - resp_rdata is 0 for stores and for errors; resp_err = captured err flag.
- Latency from accept edge N until resp_valid is high:
  - Error: cycle N+1.
  - Word store: N+2.
  - Load: N+2.
  - Sub-word store: N+3.
- Back-to-back: a new request can be accepted on the edge that leaves RESP only if req_ready is high in that cycle. Since req_ready is 0 in RESP, the next accept happens at the earliest one cycle later, in IDLE.
- Idle outputs: mem_addr=0, mem_wd=0, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0.
- Reset:
  - On any posedge with reset==0: state->IDLE, rbuf and captured request regs -> 0, all outputs -> 0.
  - mem_we is gated by reset combinationally, so a WRITE cycle with reset low writes nothing.
  - Reset mid-operation aborts the access with no response.
- req_valid while not ready is ignored; the pipeline must hold it.

Optional Feature:
- Macro LSU_TRACE_EN.
- Defined: on every posedge where mem_we is actually asserted, print $display("@%h: *%h <= %h", pc, mem_addr, mem_wd) using the captured PC. The address printed is the word-aligned address and the data is the merged word.
- Undefined: no display statements are compiled and behaviour is otherwise identical.

Test Plan:
- Word store/load: store 0x12345678 at 0x8, then load word at 0x8 -> mem_we for exactly one cycle with mem_wd=0x12345678; load returns resp_rdata=0x12345678 at N+2, resp_err=0.
- Byte RMW: mem[0x4]=0xAABBCCDD; store byte 0x11 at 0x6 -> READ then WRITE with mem_wd=0xAA11CCDD; resp_valid at N+3.
- Half load extension: mem[0x0]=0x8001_7FFF:
  - load half signed at 0x2 -> 0xFFFF8001.
  - load half unsigned at 0x2 -> 0x00008001.
  - load byte signed at 0x0 -> 0xFFFFFFFF.
- Errors, each with no mem_we and resp_err=1 at N+1, resp_rdata=0:
  - store half at 0x3.
  - load word at 0x2.
  - size 11.
  - word at address 4*MEM_WORDS.
- Reset mid-op: drop reset to 0 during the WRITE cycle of a byte store -> memory unchanged, no resp_valid; after release, req_ready=1 and the next request completes normally.
- Handshake: hold req_valid high for back-to-back loads -> req_ready low from accept through RESP; each request is accepted exactly once; resp_valid pulses exactly one cycle per request.

Source files
------------

// File: rtl/lsu_subword_master.sv
// Load/store initiator: turns byte/half/word requests into whole-word memory cycles.
// Optional trace of memory writes is compiled in when LSU_TRACE_EN is defined.
module lsu_subword_master #(
  parameter int MEM_WORDS = 3072,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // READ  | fetch target word into rbuf (loads and sub-word stores)
  // WRITE | write merged or full word to memory
  // RESP  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);

  state_t            state, state_nx;
  logic              we_q, sign_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rbuf;
  logic              accept, req_err;
  logic [31:0]       merged, load_val;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || ((req_addr >> 2) >= WORD_LIMIT);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                           state_nx = RESP;
          else if (req_we && req_size == 2'b10)  state_nx = WRITE;
          else                                   state_nx = READ;
        end
      end
      READ:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == READ) rbuf <= mem_rd;
    end
  end

  // Little-endian lanes: byte k lives at bits [8k+7:8k].
  always_comb begin
    merged = rbuf;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    lane_b = rbuf[{addr_q[1:0], 3'b000} +: 8];
    lane_h = rbuf[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{sign_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_val = rbuf;
    endcase
  end

  always_comb begin
    mem_addr   = (state == READ || state == WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_we     = (state == WRITE) && reset;
    mem_wd     = (state == WRITE) ? merged : '0;
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = (state == RESP && !we_q && !err_q) ? load_val : '0;
  end

`ifdef LSU_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (!reset)      pc_q <= '0;
    else if (accept) pc_q <= req_pc;
  end

  always_ff @(posedge clk) begin
    if (mem_we) $display("@%h: *%h <= %h", pc_q, mem_addr, mem_wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule
